// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, keyboard command/response bytes
// and the host-to-device frame helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        XFER,
        DONE
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // Shift-out frame {odd parity, data}, sent LSB first.
    typedef struct packed {
        logic       parity;
        logic [7:0] data;
    } ps2_frame_t;

    function automatic ps2_frame_t ps2_frame(input logic [7:0] d);
        ps2_frame_t f;
        f.parity = ~^d;
        f.data   = d;
        return f;
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizer for an asynchronous PS/2 pin plus falling-edge detect
// from a third history flop. Shared by the transmit and receive paths.
module ps2_edge_sync (
    input  logic clk,
    input  logic clrn,
    input  logic pin,
    output logic level,
    output logic fall_c
);

    logic [2:0] sync_q;

    // Lines idle high, so reset the chain to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], pin};
        end
    end

    assign level  = sync_q[1];
    assign fall_c = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift out
// data/parity/stop on device clock falls, then sample the device line ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned EDG_W = 4;

    logic             clk_fall_c;
    logic             clk_level;
    logic [1:0]       dat_sync_q;
    logic             dat_s;

    ps2_state_e       state,       state_nx;
    logic [8:0]       shift_q,     shift_nx;
    logic [EDG_W-1:0] edge_cnt,    edge_nx;
    logic [INH_W-1:0] inh_cnt,     inh_nx;
    logic [TO_W-1:0]  to_cnt,      to_nx;
    logic             clk_oe_nx,   dat_oe_nx;
    logic             done_nx,     ack_err_nx,  timeout_err_nx;
    logic             tx_ready_nx, busy_nx;

    ps2_edge_sync u_clk_sync (
        .clk    (clk),
        .clrn   (clrn),
        .pin    (ps2_clk),
        .level  (clk_level),
        .fall_c (clk_fall_c)
    );

    // Data pin only needs a plain two-flop synchronizer.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dat_sync_q <= 2'b11;
        end else begin
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
        end
    end

    assign dat_s = dat_sync_q[1];

    // State and registered outputs; reset releases both lines immediately.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            shift_q     <= '0;
            edge_cnt    <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_dat_oe  <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            shift_q     <= shift_nx;
            edge_cnt    <= edge_nx;
            inh_cnt     <= inh_nx;
            to_cnt      <= to_nx;
            ps2_clk_oe  <= clk_oe_nx;
            ps2_dat_oe  <= dat_oe_nx;
            done        <= done_nx;
            ack_err     <= ack_err_nx;
            timeout_err <= timeout_err_nx;
            tx_ready    <= tx_ready_nx;
            busy        <= busy_nx;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx       = state;
        shift_nx       = shift_q;
        edge_nx        = edge_cnt;
        inh_nx         = inh_cnt;
        to_nx          = to_cnt;
        clk_oe_nx      = ps2_clk_oe;
        dat_oe_nx      = ps2_dat_oe;
        done_nx        = 1'b0;
        ack_err_nx     = 1'b0;
        timeout_err_nx = 1'b0;

        unique case (state)
            IDLE: begin
                clk_oe_nx = 1'b0;
                dat_oe_nx = 1'b0;
                if (tx_valid && tx_ready) begin
                    shift_nx  = ps2_frame(tx_data);
                    edge_nx   = '0;
                    inh_nx    = '0;
                    clk_oe_nx = 1'b1;
                    state_nx  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    dat_oe_nx = 1'b1;
                    state_nx  = RTS;
                end else begin
                    inh_nx = inh_cnt + INH_W'(1);
                end
            end
            RTS: begin
                clk_oe_nx = 1'b0;
                to_nx     = '0;
                state_nx  = XFER;
            end
            XFER: begin
                // The ACK edge takes priority over a coincident timeout.
                if (clk_fall_c && edge_cnt == EDG_W'(10)) begin
                    dat_oe_nx  = 1'b0;
                    done_nx    = ~dat_s;
                    ack_err_nx = dat_s;
                    state_nx   = DONE;
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    clk_oe_nx      = 1'b0;
                    dat_oe_nx      = 1'b0;
                    timeout_err_nx = 1'b1;
                    state_nx       = IDLE;
                end else begin
                    to_nx = to_cnt + TO_W'(1);
                    if (clk_fall_c) begin
                        edge_nx = edge_cnt + EDG_W'(1);
                        if (edge_cnt == EDG_W'(9)) begin
                            dat_oe_nx = 1'b0;
                        end else begin
                            dat_oe_nx = ~shift_q[0];
                            shift_nx  = {1'b0, shift_q[8:1]};
                        end
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                clk_oe_nx = 1'b0;
                dat_oe_nx = 1'b0;
                state_nx  = IDLE;
            end
        endcase

        tx_ready_nx = (state_nx == IDLE);
        busy_nx     = (state_nx != IDLE);
    end

    // Clock level is consumed only through the edge detector here.
    logic unused_ok;
    assign unused_ok = clk_level;

endmodule
